// File: rtl/data_stack_if.sv
// Operand-side bus of the Forth data stack: op/data in, T/N/depth/flags out.
interface data_stack_if #(
    parameter int WIDTH = 16,
    parameter int DW    = 5
);
    logic [2:0]       stk_op;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] N;
    logic [DW-1:0]    depth;
    logic             ovf;
    logic             unf;

    modport master (
        output stk_op, din, err_clr,
        input  T, N, depth, ovf, unf
    );

    modport slave (
        input  stk_op, din, err_clr,
        output T, N, depth, ovf, unf
    );
endinterface

// File: rtl/data_stack.sv
// Forth data stack: T and N in registers, deeper entries spilled to an array.
// Build option DSTACK_GUARD_EN enables overflow/underflow checking and op suppression.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int DW    = 5
) (
    input logic        clk,
    input logic        rst,
    data_stack_if.slave bus
);
    localparam int AW = (DEPTH - 2 > 1) ? $clog2(DEPTH - 2) : 1;

`ifdef DSTACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam logic [2:0] OP_SET_T   = 3'd1;
    localparam logic [2:0] OP_PUSH    = 3'd2;
    localparam logic [2:0] OP_POP     = 3'd3;
    localparam logic [2:0] OP_POP_SET = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;

    logic [WIDTH-1:0] arr_r [DEPTH-2];
    logic [WIDTH-1:0] t_r, n_r, t_nxt_s, n_nxt_s, fill_s;
    logic [DW-1:0]    depth_r, depth_nxt_s;
    logic             ovf_r, unf_r, ovf_hit_s, unf_hit_s, spill_s;
    logic [AW-1:0]    spill_idx_s, sp_idx_s;

    // Array index wraps modulo the spill array size; a no-op when guarded.
    function automatic logic [AW-1:0] wrap_idx(input logic [DW-1:0] v);
        return AW'(v % DW'(DEPTH - 2));
    endfunction

    assign spill_idx_s = wrap_idx(depth_r - DW'(2));
    assign sp_idx_s    = wrap_idx(depth_r - DW'(3));

    // Refill source for N: third entry when it exists, otherwise a clean zero.
    always_comb begin
        if (depth_r >= DW'(3)) begin
            fill_s = arr_r[sp_idx_s];
        end else begin
            fill_s = '0;
        end
    end

    // Next-state decode of the stack op, with fault suppression when guarded.
    always_comb begin
        t_nxt_s     = t_r;
        n_nxt_s     = n_r;
        depth_nxt_s = depth_r;
        spill_s     = 1'b0;
        ovf_hit_s   = 1'b0;
        unf_hit_s   = 1'b0;
        case (bus.stk_op)
            OP_SET_T: begin
                if (GUARD && depth_r == DW'(0)) begin
                    unf_hit_s = 1'b1;
                end else begin
                    t_nxt_s = bus.din;
                end
            end
            OP_PUSH: begin
                if (GUARD && depth_r == DW'(DEPTH)) begin
                    ovf_hit_s = 1'b1;
                end else begin
                    t_nxt_s     = bus.din;
                    n_nxt_s     = t_r;
                    depth_nxt_s = depth_r + DW'(1);
                    spill_s     = (depth_r >= DW'(2));
                end
            end
            OP_POP: begin
                if (GUARD && depth_r == DW'(0)) begin
                    unf_hit_s = 1'b1;
                end else begin
                    t_nxt_s     = n_r;
                    n_nxt_s     = fill_s;
                    depth_nxt_s = depth_r - DW'(1);
                end
            end
            OP_POP_SET: begin
                if (GUARD && depth_r < DW'(2)) begin
                    unf_hit_s = 1'b1;
                end else begin
                    t_nxt_s     = bus.din;
                    n_nxt_s     = fill_s;
                    depth_nxt_s = depth_r - DW'(1);
                end
            end
            OP_SWAP: begin
                if (GUARD && depth_r < DW'(2)) begin
                    unf_hit_s = 1'b1;
                end else begin
                    t_nxt_s = n_r;
                    n_nxt_s = t_r;
                end
            end
            default: begin
                t_nxt_s = t_r;
            end
        endcase
    end

    // Stack registers and sticky flags; a new fault beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r     <= '0;
            n_r     <= '0;
            depth_r <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            t_r     <= t_nxt_s;
            n_r     <= n_nxt_s;
            depth_r <= depth_nxt_s;
            ovf_r   <= ovf_hit_s | (ovf_r & ~bus.err_clr);
            unf_r   <= unf_hit_s | (unf_r & ~bus.err_clr);
        end
    end

    // Spill array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (spill_s) begin
            arr_r[spill_idx_s] <= n_r;
        end
    end

    assign bus.T     = t_r;
    assign bus.N     = n_r;
    assign bus.depth = depth_r;
    assign bus.ovf   = ovf_r;
    assign bus.unf   = unf_r;
endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack (default and DSTACK_GUARD_EN builds).
module tb_data_stack;
    localparam logic [2:0] NOP = 3'd0, SET_T = 3'd1, PUSH = 3'd2, POP = 3'd3,
                           POP_SET = 3'd4, SWAP = 3'd5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_stack_if #(.WIDTH(16), .DW(5)) bus ();

    data_stack #(.WIDTH(16), .DEPTH(16), .DW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic [15:0] d, input logic clr);
        bus.stk_op  = op;
        bus.din     = d;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        bus.stk_op  = NOP;
        bus.din     = 16'h0000;
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_tnd(input string tag, input logic [15:0] t, input logic [15:0] n,
                           input logic [4:0] d);
        chk({tag, "_T"}, 32'(bus.T), 32'(t));
        chk({tag, "_N"}, 32'(bus.N), 32'(n));
        chk({tag, "_depth"}, 32'(bus.depth), 32'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.stk_op  = NOP;
        bus.din     = 16'h0000;
        bus.err_clr = 1'b0;
        #2;
        chk_tnd("reset", 16'h0000, 16'h0000, 5'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
        chk("reset_unf", 32'(bus.unf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Push 1..4 then pop three times
        step(PUSH, 16'd1, 1'b0);
        step(PUSH, 16'd2, 1'b0);
        step(PUSH, 16'd3, 1'b0);
        step(PUSH, 16'd4, 1'b0);
        chk_tnd("push4", 16'd4, 16'd3, 5'd4);
        step(POP, 16'h0000, 1'b0);
        chk_tnd("pop1", 16'd3, 16'd2, 5'd3);
        step(POP, 16'h0000, 1'b0);
        chk_tnd("pop2", 16'd2, 16'd1, 5'd2);
        step(POP, 16'h0000, 1'b0);
        chk_tnd("pop3", 16'd1, 16'd0, 5'd1);
        step(SET_T, 16'h00AA, 1'b0);
        chk_tnd("set_t", 16'h00AA, 16'd0, 5'd1);

        // Asynchronous reset mid-stream at depth 5
        step(PUSH, 16'd10, 1'b0);
        step(PUSH, 16'd11, 1'b0);
        step(PUSH, 16'd12, 1'b0);
        step(PUSH, 16'd13, 1'b0);
        chk_tnd("pre_rst", 16'd13, 16'd12, 5'd5);
        #2;
        rst = 1'b1;
        #1;
        chk_tnd("async_rst", 16'h0000, 16'h0000, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // Binary op
        step(PUSH, 16'd7, 1'b0);
        step(PUSH, 16'd5, 1'b0);
        step(POP_SET, 16'd12, 1'b0);
        chk_tnd("pop_set", 16'd12, 16'd0, 5'd1);
        chk("pop_set_unf", 32'(bus.unf), 32'd0);

        // SWAP with T=9, N=4, then drain to depth 1
        step(PUSH, 16'd4, 1'b0);
        step(PUSH, 16'd9, 1'b0);
        step(SWAP, 16'h0000, 1'b0);
        chk_tnd("swap", 16'd4, 16'd9, 5'd3);
        step(POP, 16'h0000, 1'b0);
        chk_tnd("swap_pop1", 16'd9, 16'd12, 5'd2);
        step(POP, 16'h0000, 1'b0);
        chk_tnd("swap_pop2", 16'd12, 16'd0, 5'd1);
        step(SWAP, 16'h0000, 1'b0);
`ifdef DSTACK_GUARD_EN
        chk_tnd("swap_unf", 16'd12, 16'd0, 5'd1);
        chk("swap_unf_flag", 32'(bus.unf), 32'd1);
        step(SWAP, 16'h0000, 1'b1);
        chk("clr_vs_fault", 32'(bus.unf), 32'd1);
        step(NOP, 16'h0000, 1'b1);
        chk("unf_clr", 32'(bus.unf), 32'd0);
`else
        chk_tnd("swap_d1_nochk", 16'd0, 16'd12, 5'd1);
        chk("swap_d1_unf", 32'(bus.unf), 32'd0);
`endif

        // Fill to full depth, overflow attempt, then LIFO drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(PUSH, 16'h0100 + 16'(i), 1'b0);
        end
        chk_tnd("full", 16'h010F, 16'h010E, 5'd16);
`ifdef DSTACK_GUARD_EN
        step(PUSH, 16'hBEEF, 1'b0);
        chk_tnd("ovf_push", 16'h010F, 16'h010E, 5'd16);
        chk("ovf_flag", 32'(bus.ovf), 32'd1);
        step(NOP, 16'h0000, 1'b1);
        chk("ovf_clr", 32'(bus.ovf), 32'd0);
`endif
        for (int k = 1; k <= 14; k++) begin
            step(POP, 16'h0000, 1'b0);
            chk("lifo_T", 32'(bus.T), 32'(16'h010F - 16'(k)));
        end
        chk_tnd("drained", 16'h0101, 16'h0100, 5'd2);
        step(POP, 16'h0000, 1'b0);
        step(POP, 16'h0000, 1'b0);
        chk_tnd("empty", 16'h0000, 16'h0000, 5'd0);

        // Pop from empty
        step(POP, 16'h0000, 1'b0);
`ifdef DSTACK_GUARD_EN
        chk_tnd("pop_empty", 16'h0000, 16'h0000, 5'd0);
        chk("pop_empty_unf", 32'(bus.unf), 32'd1);
`else
        chk("wrap_depth", 32'(bus.depth), 32'd31);
        chk("wrap_ovf", 32'(bus.ovf), 32'd0);
        chk("wrap_unf", 32'(bus.unf), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
